issue_queue: RTL and testbench
==============================

// Module: issue_queue
// PURPOSE
//   In-order issue queue between ID and the register-read/issue stage.
//   Buffers decoded packets from ID (ds_to_is_bus) so a downstream stall does not stall decode.
//   Drives IQ_allowin back to ID and presents the oldest entry to the issue stage.
//   Decoupling depth is set by DEPTH.
// PARAMETERS
//   DEPTH  4                  number of entries; power of two, >= 2
//   WIDTH  `DS_TO_IS_BUS_WD   packet width in bits; equals the ID->IS bus
// PORTS
//   clk             in   1      core clock; all state updates on posedge
//   reset           in   1      asynchronous, active-high reset
//   iq_flush        in   1      discard all entries (mispredict/exception redirect)
//   ds_to_is_valid  in   1      ID presents a packet
//   ds_to_is_bus    in   WIDTH  decoded packet from ID
//   IQ_allowin      out  1      queue can accept a packet this cycle
//   is_to_rf_valid  out  1      head entry valid toward issue/RF stage
//   is_to_rf_bus    out  WIDTH  head packet (oldest)
//   rf_allowin      in   1      downstream accepts head this cycle
//   iq_count        out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//   - Circular buffer: wr_ptr, rd_ptr ($clog2(DEPTH) bits, natural wrap), count ($clog2(DEPTH)+1 bits).
//   - Reset (async): wr_ptr = 0, rd_ptr = 0, count = 0.
//     Outputs after reset: is_to_rf_valid = 0, IQ_allowin = 1, iq_count = 0.
//     Entry storage is not reset; is_to_rf_bus is don't-care while is_to_rf_valid = 0.
//   - Push: ds_to_is_valid && IQ_allowin && !iq_flush.
//     Write at wr_ptr, then wr_ptr += 1.
//   - Pop: is_to_rf_valid && rf_allowin && !iq_flush. Then rd_ptr += 1.
//   - count' = count + push - pop. Simultaneous push and pop leave count unchanged.
//   - IQ_allowin = (count != DEPTH). It is a function of registered state only.
//     It never depends combinationally on rf_allowin, which breaks the ID<-IQ<-RF ready chain.
//     When full, a same-cycle pop does not allow a push.
//   - is_to_rf_valid = (count != 0). is_to_rf_bus = entry[rd_ptr].
//   - Latency: a packet pushed at edge N is visible at the head no earlier than cycle N+1.
//   - Ordering: strict FIFO. No reordering, no duplication, no loss except on flush.
//   - Flush: iq_flush has priority over push and pop in the same cycle.
//     Next cycle: count = 0, pointers equal (both reset to 0).
//     The packet offered that cycle is dropped; the head is not consumed.
//   - Full: IQ_allowin = 0; ds_to_is_bus is ignored.
//   - Empty: is_to_rf_valid = 0; rf_allowin is ignored.
//   - Reset asserted mid-operation clears all state immediately (asynchronous).
// CONFIGURATION
//   IQ_BYPASS_EN defined:
//     When count == 0 and ds_to_is_valid && rf_allowin && !iq_flush, the input packet passes
//     combinationally to is_to_rf_bus with is_to_rf_valid = 1. No write, count stays 0.
//     Zero-cycle latency when empty.
//     If rf_allowin = 0 while empty, the packet is written normally.
//   IQ_BYPASS_EN undefined:
//     Every packet is written first. Minimum latency is 1 cycle.
//     No combinational path from ds_to_is_* to is_to_rf_*.
// STRUCTURE
//   - myCPU.vh (shared header):
//     `IQ_DEPTH default (4); reuse `DS_TO_IS_BUS_WD.
//     No new bus layout: the queue is payload-agnostic.
//   - Sub-module iq_entry_array:
//     DEPTH x WIDTH register file, 1 write port (we, waddr, wdata), 1 async read port (raddr, rdata).
//   - issue_queue holds the pointers, count, handshake and flush logic, and the optional bypass mux.
// TESTING
//   1. Reset, then 4 pushes (pkts A..D), rf_allowin = 0:
//      IQ_allowin -> 0 after the 4th push; iq_count = 4; head = A.
//   2. Full, ds_to_is_valid = 1, rf_allowin = 1 for one cycle:
//      A popped; E not accepted; iq_count = 3; IQ_allowin = 1 next cycle.
//   3. count = 2, push and pop in the same cycle:
//      iq_count stays 2; output order A,B,C exactly.
//   4. count = 3, iq_flush with push and pop asserted:
//      next cycle iq_count = 0, is_to_rf_valid = 0.
//      Neither the pushed nor the head packet appears later.
//   5. Pointer wrap: stream 10 packets with alternating rf_allowin:
//      output sequence equals input sequence; no gaps or duplicates.
//   6. Empty, push X with rf_allowin = 1:
//      IQ_BYPASS_EN defined -> X at head the same cycle, iq_count stays 0.
//      IQ_BYPASS_EN undefined -> X at head next cycle.

Source files
------------

// File: rtl/issue_queue_pkg.sv
// Shared constants for the ID -> IS issue queue.
//   IQ_DEPTH        : default queue depth (power of two, >= 2)
//   DS_TO_IS_BUS_WD : width of the decoded packet handed from ID to IS
// The queue never looks inside a packet, so no bus layout is defined here.
package issue_queue_pkg;

  localparam int IQ_DEPTH        = 4;
  localparam int DS_TO_IS_BUS_WD = 32;

endpackage

// File: rtl/iq_entry_array.sv
// Entry storage for the issue queue: DEPTH x WIDTH register file.
// Ports:
//   clk    : clock, writes happen on posedge
//   we     : write enable
//   waddr  : write slot
//   wdata  : packet to store
//   raddr  : read slot (asynchronous read)
//   rdata  : packet held in slot raddr
// Storage is intentionally not reset; the queue only reads slots it has written.
module iq_entry_array #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Single write port, no reset on the payload.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/issue_queue.sv
// In-order issue queue between ID and the register-read/issue stage.
// Decouples decode from downstream stalls and presents the oldest packet.
// Ports:
//   clk            : core clock
//   reset          : asynchronous, active-high reset
//   iq_flush       : drop every entry (redirect); beats push and pop
//   ds_to_is_valid : ID offers a packet
//   ds_to_is_bus   : packet from ID
//   IQ_allowin     : queue can accept a packet (registered state only)
//   is_to_rf_valid : head packet valid toward issue/RF
//   is_to_rf_bus   : head packet (oldest)
//   rf_allowin     : downstream takes the head this cycle
//   iq_count       : current occupancy
// Build option:
//   IQ_BYPASS_EN : when the queue is empty and downstream is ready, an incoming
//                  packet goes straight to the head in the same cycle without
//                  being written. Undefined: every packet is stored first.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int WIDTH = DS_TO_IS_BUS_WD
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     iq_flush,
  input  logic                     ds_to_is_valid,
  input  logic [WIDTH-1:0]         ds_to_is_bus,
  output logic                     IQ_allowin,
  output logic                     is_to_rf_valid,
  output logic [WIDTH-1:0]         is_to_rf_bus,
  input  logic                     rf_allowin,
  output logic [$clog2(DEPTH):0]   iq_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             not_empty;
  logic             bypass;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head_data;

  assign not_empty  = (count != '0);
  // Full-ness comes from the count register only, so rf_allowin never
  // reaches IQ_allowin combinationally and a pop cannot free a slot for a
  // same-cycle push when full.
  assign IQ_allowin = (count != CW'(DEPTH));

`ifdef IQ_BYPASS_EN
  // Empty queue with a ready consumer: hand the packet straight through.
  assign bypass = !not_empty && ds_to_is_valid && rf_allowin && !iq_flush;
`else
  assign bypass = 1'b0;
`endif

  assign push = ds_to_is_valid && IQ_allowin && !iq_flush && !bypass;
  assign pop  = not_empty && rf_allowin && !iq_flush;

  iq_entry_array #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_entries (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (ds_to_is_bus),
    .raddr (rd_ptr),
    .rdata (head_data)
  );

  // Pointers wrap naturally because DEPTH is a power of two. A flush
  // returns both pointers to zero so the queue restarts from a known slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (iq_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign is_to_rf_valid = not_empty || bypass;
  assign is_to_rf_bus   = bypass ? ds_to_is_bus : head_data;
  assign iq_count       = count;

endmodule

// File: tb/tb_issue_queue.sv
// Directed testbench for issue_queue (DEPTH 4, 32-bit packets).
// Inputs change one time unit after the rising edge; outputs are observed
// one time unit after that, well clear of the active edge.
module tb_issue_queue;

  logic        clk;
  logic        reset;
  logic        iq_flush;
  logic        ds_to_is_valid;
  logic [31:0] ds_to_is_bus;
  logic        IQ_allowin;
  logic        is_to_rf_valid;
  logic [31:0] is_to_rf_bus;
  logic        rf_allowin;
  logic [2:0]  iq_count;

  int checks;
  int failures;

  logic [31:0] pkt [4];

  issue_queue #(
    .DEPTH (4),
    .WIDTH (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .iq_flush       (iq_flush),
    .ds_to_is_valid (ds_to_is_valid),
    .ds_to_is_bus   (ds_to_is_bus),
    .IQ_allowin     (IQ_allowin),
    .is_to_rf_valid (is_to_rf_valid),
    .is_to_rf_bus   (is_to_rf_bus),
    .rf_allowin     (rf_allowin),
    .iq_count       (iq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iq_flush       = 1'b0;
    ds_to_is_valid = 1'b0;
    ds_to_is_bus   = '0;
    rf_allowin     = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #23;
    checks++;
    if (is_to_rf_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b want=0", is_to_rf_valid);
    end
    checks++;
    if (IQ_allowin !== 1'b1) begin
      failures++;
      $display("FAIL reset_allowin got=%b want=1", IQ_allowin);
    end
    checks++;
    if (iq_count !== 3'd0) begin
      failures++;
      $display("FAIL reset_count got=%0d want=0", iq_count);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Fill with A..D while downstream stalls.
  task automatic test_fill();
    pkt[0] = 32'hAAAA_0001;
    pkt[1] = 32'hBBBB_0002;
    pkt[2] = 32'hCCCC_0003;
    pkt[3] = 32'hDDDD_0004;
    rf_allowin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ds_to_is_valid = 1'b1;
      ds_to_is_bus   = pkt[i];
      tick();
      checks++;
      if (iq_count !== 3'(i + 1)) begin
        failures++;
        $display("FAIL fill_count[%0d] got=%0d want=%0d", i, iq_count, i + 1);
      end
    end
    ds_to_is_valid = 1'b0;
    #1;
    checks++;
    if (IQ_allowin !== 1'b0) begin
      failures++;
      $display("FAIL fill_allowin got=%b want=0", IQ_allowin);
    end
    checks++;
    if (is_to_rf_valid !== 1'b1 || is_to_rf_bus !== pkt[0]) begin
      failures++;
      $display("FAIL fill_head got=%b/%h want=1/%h", is_to_rf_valid, is_to_rf_bus, pkt[0]);
    end
  endtask

  // Full: offer E while popping A; E must be refused.
  task automatic test_full_pop();
    ds_to_is_valid = 1'b1;
    ds_to_is_bus   = 32'hEEEE_0005;
    rf_allowin     = 1'b1;
    #1;
    checks++;
    if (IQ_allowin !== 1'b0) begin
      failures++;
      $display("FAIL full_allowin_with_rf_ready got=%b want=0", IQ_allowin);
    end
    tick();
    ds_to_is_valid = 1'b0;
    rf_allowin     = 1'b0;
    #1;
    checks++;
    if (iq_count !== 3'd3) begin
      failures++;
      $display("FAIL full_pop_count got=%0d want=3", iq_count);
    end
    checks++;
    if (IQ_allowin !== 1'b1) begin
      failures++;
      $display("FAIL full_pop_allowin got=%b want=1", IQ_allowin);
    end
    rf_allowin = 1'b1;
    for (int k = 1; k < 4; k++) begin
      #1;
      checks++;
      if (is_to_rf_valid !== 1'b1 || is_to_rf_bus !== pkt[k]) begin
        failures++;
        $display("FAIL drain_head[%0d] got=%b/%h want=1/%h", k, is_to_rf_valid, is_to_rf_bus, pkt[k]);
      end
      tick();
    end
    rf_allowin = 1'b0;
    #1;
    checks++;
    if (is_to_rf_valid !== 1'b0 || iq_count !== 3'd0) begin
      failures++;
      $display("FAIL drain_empty got=%b/%0d want=0/0", is_to_rf_valid, iq_count);
    end
  endtask

  // Two entries, then push C while popping A; count holds at 2.
  task automatic test_push_pop();
    logic [31:0] seq [3];
    seq[0] = 32'h0A0A_0A0A;
    seq[1] = 32'h0B0B_0B0B;
    seq[2] = 32'h0C0C_0C0C;
    rf_allowin = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ds_to_is_valid = 1'b1;
      ds_to_is_bus   = seq[i];
      tick();
    end
    ds_to_is_bus = seq[2];
    rf_allowin   = 1'b1;
    #1;
    checks++;
    if (is_to_rf_bus !== seq[0]) begin
      failures++;
      $display("FAIL pp_head0 got=%h want=%h", is_to_rf_bus, seq[0]);
    end
    tick();
    ds_to_is_valid = 1'b0;
    #1;
    checks++;
    if (iq_count !== 3'd2) begin
      failures++;
      $display("FAIL pp_count got=%0d want=2", iq_count);
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (is_to_rf_valid !== 1'b1 || is_to_rf_bus !== seq[i]) begin
        failures++;
        $display("FAIL pp_head[%0d] got=%b/%h want=1/%h", i, is_to_rf_valid, is_to_rf_bus, seq[i]);
      end
      tick();
    end
    rf_allowin = 1'b0;
    #1;
    checks++;
    if (iq_count !== 3'd0) begin
      failures++;
      $display("FAIL pp_final_count got=%0d want=0", iq_count);
    end
  endtask

  // Three entries, then flush together with a push and a pop.
  task automatic test_flush();
    rf_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ds_to_is_valid = 1'b1;
      ds_to_is_bus   = 32'h5000_0000 + 32'(i);
      tick();
    end
    ds_to_is_bus = 32'h5000_00FF;
    rf_allowin   = 1'b1;
    iq_flush     = 1'b1;
    tick();
    iq_flush       = 1'b0;
    ds_to_is_valid = 1'b0;
    rf_allowin     = 1'b0;
    #1;
    checks++;
    if (iq_count !== 3'd0 || is_to_rf_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_empty got=%0d/%b want=0/0", iq_count, is_to_rf_valid);
    end
    ds_to_is_valid = 1'b1;
    ds_to_is_bus   = 32'h7777_7777;
    tick();
    ds_to_is_valid = 1'b0;
    #1;
    checks++;
    if (iq_count !== 3'd1 || is_to_rf_bus !== 32'h7777_7777) begin
      failures++;
      $display("FAIL flush_next_head got=%0d/%h want=1/77777777", iq_count, is_to_rf_bus);
    end
    rf_allowin = 1'b1;
    tick();
    rf_allowin = 1'b0;
    #1;
    checks++;
    if (is_to_rf_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_stale got=%b want=0", is_to_rf_valid);
    end
  endtask

  // Stream ten packets with alternating rf_allowin; scoreboard keeps order.
  task automatic test_wrap();
    logic [31:0] q [$];
    logic [31:0] exp_head;
    logic        exp_valid;
    int          sent;
    int          recv;
    int          cyc;
    int          pre;
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < 10 && cyc < 100) begin
      rf_allowin     = cyc[0];
      ds_to_is_valid = (sent < 10);
      ds_to_is_bus   = 32'hC000_0000 + 32'(sent);
      #1;
      pre       = q.size();
      exp_valid = 1'b0;
      exp_head  = '0;
      if (pre > 0) begin
        exp_valid = 1'b1;
        exp_head  = q[0];
      end
`ifdef IQ_BYPASS_EN
      else if (ds_to_is_valid && rf_allowin) begin
        exp_valid = 1'b1;
        exp_head  = ds_to_is_bus;
      end
`endif
      checks++;
      if (iq_count !== 3'(pre) || IQ_allowin !== (pre != 4)) begin
        failures++;
        $display("FAIL wrap_state[c%0d] got=%0d/%b want=%0d/%b", cyc, iq_count, IQ_allowin, pre, pre != 4);
      end
      checks++;
      if (is_to_rf_valid !== exp_valid || (exp_valid && is_to_rf_bus !== exp_head)) begin
        failures++;
        $display("FAIL wrap_head[c%0d] got=%b/%h want=%b/%h", cyc, is_to_rf_valid, is_to_rf_bus, exp_valid, exp_head);
      end
      if (exp_valid && rf_allowin) begin
        checks++;
        if (is_to_rf_bus !== 32'hC000_0000 + 32'(recv)) begin
          failures++;
          $display("FAIL wrap_order[%0d] got=%h want=%h", recv, is_to_rf_bus, 32'hC000_0000 + 32'(recv));
        end
        recv++;
        if (pre > 0) void'(q.pop_front());
      end
      if (ds_to_is_valid && pre != 4) begin
        if (pre > 0 || !exp_valid) q.push_back(ds_to_is_bus);
        sent++;
      end
      tick();
      cyc++;
    end
    ds_to_is_valid = 1'b0;
    rf_allowin     = 1'b0;
    checks++;
    if (recv != 10) begin
      failures++;
      $display("FAIL wrap_timeout got=%0d want=10", recv);
    end
  endtask

  // Empty queue, push X with the consumer ready.
  task automatic test_bypass();
    ds_to_is_valid = 1'b1;
    ds_to_is_bus   = 32'hDEAD_BEEF;
    rf_allowin     = 1'b1;
    #1;
`ifdef IQ_BYPASS_EN
    checks++;
    if (is_to_rf_valid !== 1'b1 || is_to_rf_bus !== 32'hDEAD_BEEF || iq_count !== 3'd0) begin
      failures++;
      $display("FAIL bypass_same_cycle got=%b/%h/%0d want=1/deadbeef/0", is_to_rf_valid, is_to_rf_bus, iq_count);
    end
    tick();
    ds_to_is_valid = 1'b0;
    rf_allowin     = 1'b0;
    #1;
    checks++;
    if (is_to_rf_valid !== 1'b0 || iq_count !== 3'd0) begin
      failures++;
      $display("FAIL bypass_after got=%b/%0d want=0/0", is_to_rf_valid, iq_count);
    end
`else
    checks++;
    if (is_to_rf_valid !== 1'b0) begin
      failures++;
      $display("FAIL nobypass_same_cycle got=%b want=0", is_to_rf_valid);
    end
    tick();
    ds_to_is_valid = 1'b0;
    rf_allowin     = 1'b0;
    #1;
    checks++;
    if (is_to_rf_valid !== 1'b1 || is_to_rf_bus !== 32'hDEAD_BEEF || iq_count !== 3'd1) begin
      failures++;
      $display("FAIL nobypass_next got=%b/%h/%0d want=1/deadbeef/1", is_to_rf_valid, is_to_rf_bus, iq_count);
    end
    rf_allowin = 1'b1;
    tick();
    rf_allowin = 1'b0;
`endif
  endtask

  // Reset between edges must clear occupancy immediately.
  task automatic test_async_reset();
    ds_to_is_valid = 1'b1;
    ds_to_is_bus   = 32'h1234_5678;
    tick();
    ds_to_is_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (iq_count !== 3'd0 || is_to_rf_valid !== 1'b0 || IQ_allowin !== 1'b1) begin
      failures++;
      $display("FAIL async_reset got=%0d/%b/%b want=0/0/1", iq_count, is_to_rf_valid, IQ_allowin);
    end
    reset = 1'b0;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_fill();
    test_full_pop();
    test_push_pop();
    test_flush();
    test_wrap();
    test_bypass();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
